// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the seq_fetch front end.
// Imported by the fetch top and its skid buffer.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] ECALL_INSTR      = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {pc, instr} buffer: output register plus one skid slot.
// The caller guarantees a free slot whenever in_valid is asserted.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            skid_valid
);

  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic            out_free;

  // Output slot can take new data when empty or drained this cycle.
  assign out_free = ~out_valid | out_ready;

  // Keep program order: skid entry always precedes a new response.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_pc     <= skid_pc;
        out_instr  <= skid_instr;
        skid_valid <= in_valid;
        if (in_valid) begin
          skid_pc    <= in_pc;
          skid_instr <= in_instr;
        end
      end else if (in_valid) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_instr <= in_instr;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_instr <= in_instr;
    end
  end

endmodule

// File: rtl/seq_fetch.sv
// Instruction-fetch front end: PC, imem request issue, redirect, halt.
// Responses land in a 2-entry skid buffer feeding decode.
module seq_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            halted,
  output logic            fetch_err
);

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            skid_valid;
  logic            run;
  logic            accept;
  logic            halting;
  logic            redirect;
  logic            misalign;
  logic            flush;
  logic            fill;
  logic            issue;
  logic [1:0]      cnt;
  logic [1:0]      occ;

  assign run      = (state == RUN);
  assign accept   = if_valid & if_ready;
  assign halting  = run & accept & is_halt(if_instr);
  assign redirect = run & br_taken & ~halting;
  assign misalign = redirect & (br_target[1:0] != 2'b00);

  // Occupancy never exceeds 2, so "< 2" is just bit 1 clear.
  assign cnt = {1'b0, if_valid} + {1'b0, skid_valid}
             + {1'b0, inflight};
  assign occ = cnt - {1'b0, accept};

  assign issue     = ~rst & run & ~br_taken & ~occ[1];
  assign imem_en   = issue;
  assign imem_addr = pc_q;

  // Leaving RUN or redirecting drops everything buffered or in flight.
  assign flush = ~run | redirect | halting;
  assign fill  = inflight & ~flush;

  // PC advance, redirect load, and the outstanding-request flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc <= pc_q;
      end
      if (redirect & ~misalign) begin
        pc_q <= br_target;
      end else if (issue) begin
        pc_q <= pc_q + XLEN'(4);
      end
    end
  end

  // Run/halt/error FSM with sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (halting) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (misalign) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

  fetch_skid_buf #(
    .XLEN(XLEN)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (fill),
    .in_pc     (req_pc),
    .in_instr  (imem_rdata),
    .out_ready (if_ready),
    .out_valid (if_valid),
    .out_pc    (if_pc),
    .out_instr (if_instr),
    .skid_valid(skid_valid)
  );

endmodule

// File: tb/tb_seq_fetch.sv
// Cycle-table bench for seq_fetch with an accept-order scoreboard.
// Memory word at address A holds A>>2 unless a halt word is planted.
module tb_seq_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] halt_word = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic        fetch_err;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        chk;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        hlt;
    logic        err;
    logic        push;
    logic [31:0] ppc;
    logic        zr;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          vi = 0;

  seq_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_word != 32'h0 && a == 32'h10) return halt_word;
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  function automatic vec_t mk(
    input logic rs, input logic rd, input logic b,
    input logic [31:0] t, input logic c, input logic e,
    input logic [31:0] a, input logic v, input logic [31:0] p,
    input logic h, input logic er, input logic pu,
    input logic [31:0] pp);
    vec_t r;
    r.rst = rs; r.rdy = rd; r.br = b; r.tgt = t;
    r.chk = c; r.en = e; r.addr = a; r.vld = v;
    r.pc = p; r.hlt = h; r.err = er; r.push = pu;
    r.ppc = pp; r.zr = 1'b0;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h want %h", vi, nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] p;
    rst = v.rst;
    if_ready = v.rdy;
    br_taken = v.br;
    br_target = v.tgt;
    @(negedge clk);
    if (v.chk) begin
      cmp("imem_en", 32'(imem_en), 32'(v.en));
      if (v.en) cmp("imem_addr", imem_addr, v.addr);
      cmp("if_valid", 32'(if_valid), 32'(v.vld));
      if (v.vld) cmp("if_pc", if_pc, v.pc);
      cmp("halted", 32'(halted), 32'(v.hlt));
      cmp("fetch_err", 32'(fetch_err), 32'(v.err));
      if (v.zr) begin
        cmp("rst_pc", if_pc, 32'h0);
        cmp("rst_instr", if_instr, NOP_INSTR);
      end
    end
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL v%0d sb_extra: got pc %h want none",
                 vi, if_pc);
      end else begin
        p = exp_q.pop_front();
        cmp("sb_pc", if_pc, p);
        cmp("sb_instr", if_instr, mem_word(p));
      end
    end
    if (v.push) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++)
        exp_q.push_back(v.ppc + 32'(4 * i));
    end
    vi++;
    @(posedge clk);
    #1;
  endtask

  task automatic halt_seq(input logic [31:0] hw, input logic br7);
    halt_word = hw;
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    run_vec(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mk(0, 1, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0));
    for (int k = 3; k <= 6; k++)
      run_vec(mk(0, 1, 0, 0, 1, 1, 32'(4 * (k - 1)),
                 1, 32'(4 * (k - 3)), 0, 0, 0, 0));
    run_vec(mk(0, 1, br7, 32'h102, 1, ~br7, 32'h18,
               1, 32'h10, 0, 0, 0, 0));
    run_vec(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      run_vec(mk(0, 1, 1, 32'h40, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    run_vec(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    run_vec(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    vec_t r;
    // reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    r = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    r.zr = 1'b1;
    tbl.push_back(r);
    // startup and streaming
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'hC, 1, 4, 0, 0, 0, 0));
    // stall at pc 0x8
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h10, 1, 8, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h14, 1, 'hC, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h18, 1, 'h10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h1C, 1, 'h14, 0, 0, 0, 0));
    // redirect with concurrent accept
    tbl.push_back(mk(0, 1, 1, 'h100, 1, 0, 0, 1, 'h18,
                     0, 0, 1, 'h100));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h100, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h104, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h108, 1, 'h100, 0, 0, 0, 0));
    // redirect while skid is full
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 'h104, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 'h104, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h200, 1, 0, 0, 1, 'h104,
                     0, 0, 1, 'h200));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h200, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h204, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h208, 1, 'h200, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'h20C, 1, 'h204, 0, 0, 0, 0));
    // misaligned redirect, then ignored redirect, then reset
    tbl.push_back(mk(0, 1, 1, 'h102, 1, 0, 0, 1, 'h208, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 'h300, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // ECALL at 0x10, then EBREAK racing a misaligned redirect
    halt_seq(ECALL_INSTR, 1'b0);
    halt_seq(EBREAK_INSTR, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
